// File: rtl/sampled_pfd.sv
// Sampled phase-frequency detector: synchronises IN/FB, runs an UP/DN tri-state
// detector, measures each phase error in CLK cycles and tracks loop lock.
module sampled_pfd #(
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEADZONE    = 1,
  parameter int unsigned LOCK_CNT    = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    IN,
  input  logic                    FB,
  output logic                    flagU,
  output logic                    flagD,
  output logic signed [ERR_W-1:0] phase_err,
  output logic                    err_valid,
  output logic                    locked
);

  localparam int unsigned CNT_W = ERR_W - 1;
  localparam int unsigned LCK_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX  = {1'b0, CNT_MAX};
  localparam logic [ERR_W-1:0] DZ       = ERR_W'(DEADZONE);
  localparam logic [LCK_W-1:0] LOCK_MAX = LCK_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] in_sync;
  logic [SYNC_STAGES-1:0] fb_sync;
  logic                   in_hist;
  logic                   fb_hist;
  logic                   in_rise;
  logic                   fb_rise;

  state_t                  state;
  state_t                  state_d;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_d;
  logic [CNT_W-1:0]        cnt_inc;
  logic signed [ERR_W-1:0] pos_err;
  logic signed [ERR_W-1:0] perr_d;
  logic                    ev_d;

  logic [ERR_W-1:0] err_mag;
  logic             in_window;
  logic [LCK_W-1:0] lock_cnt;
  logic [LCK_W-1:0] lock_cnt_d;

  // Synchronisers plus history flop; a level already high at reset release reads as an edge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      in_sync <= '0;
      fb_sync <= '0;
      in_hist <= 1'b0;
      fb_hist <= 1'b0;
    end else begin
      in_sync <= {in_sync[SYNC_STAGES-2:0], IN};
      fb_sync <= {fb_sync[SYNC_STAGES-2:0], FB};
      in_hist <= in_sync[SYNC_STAGES-1];
      fb_hist <= fb_sync[SYNC_STAGES-1];
    end
  end

  assign in_rise = in_sync[SYNC_STAGES-1] & ~in_hist;
  assign fb_rise = fb_sync[SYNC_STAGES-1] & ~fb_hist;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign pos_err = signed'({1'b0, cnt});

  // Detector next-state, measurement counter and error capture
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    perr_d  = phase_err;
    ev_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_rise && fb_rise) begin
          perr_d = '0;
          ev_d   = 1'b1;
        end else if (in_rise) begin
          state_d = UP;
          cnt_d   = CNT_ONE;
        end else if (fb_rise) begin
          state_d = DN;
          cnt_d   = CNT_ONE;
        end
      end
      UP: begin
        if (fb_rise) begin
          perr_d = pos_err;
          ev_d   = 1'b1;
          if (in_rise) begin
            cnt_d = CNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DN: begin
        if (in_rise) begin
          perr_d = -pos_err;
          ev_d   = 1'b1;
          if (fb_rise) begin
            cnt_d = CNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      phase_err <= '0;
      err_valid <= 1'b0;
      flagU     <= 1'b0;
      flagD     <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      phase_err <= perr_d;
      err_valid <= ev_d;
      flagU     <= (state_d == UP);
      flagD     <= (state_d == DN);
    end
  end

  // A magnitude equal to the counter ceiling may be a clipped reading, so it never counts as in-window
  assign err_mag   = phase_err[ERR_W-1] ? ERR_W'(-phase_err) : ERR_W'(phase_err);
  assign in_window = (err_mag <= DZ) && (err_mag != ERR_MAX);

  always_comb begin
    lock_cnt_d = lock_cnt;
    if (err_valid) begin
      if (!in_window) begin
        lock_cnt_d = '0;
      end else if (lock_cnt != LOCK_MAX) begin
        lock_cnt_d = lock_cnt + LCK_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      lock_cnt <= lock_cnt_d;
      locked   <= (lock_cnt_d == LOCK_MAX);
    end
  end

endmodule

// File: tb/tb_sampled_pfd.sv
// Directed bench for sampled_pfd: each IN/FB pair is scored for flag width,
// edge latency, error value, strobe count and lock response.
module tb_sampled_pfd;

  logic       CLK;
  logic       RESET;
  logic       IN;
  logic       FB;
  logic       flagU;
  logic       flagD;
  logic [7:0] phase_err;
  logic       err_valid;
  logic       locked;

  int checks;
  int errors;

  int up_n, dn_n, ev_n, both_n, up_gap;
  int first_up, first_dn, ev_cycle;
  int lock_at_ev, lock_after;
  logic [7:0] ev_err;
  logic       prev_ev;

  sampled_pfd #(
    .ERR_W(8), .SYNC_STAGES(2), .DEADZONE(1), .LOCK_CNT(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .FB(FB),
    .flagU(flagU), .flagD(flagD), .phase_err(phase_err),
    .err_valid(err_valid), .locked(locked)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    up_n = 0; dn_n = 0; ev_n = 0; both_n = 0; up_gap = 0;
    first_up = -1; first_dn = -1; ev_cycle = -1;
    lock_at_ev = -1; lock_after = -1;
    ev_err = 8'h00; prev_ev = 1'b0;
  endtask

  // One clock, then sample 1 ns after the edge and accumulate statistics
  task automatic observe(input int c);
    @(posedge CLK);
    #1;
    if (prev_ev) lock_after = int'(locked);
    prev_ev = err_valid;
    if (flagU) begin
      up_n++;
      if (first_up < 0) first_up = c;
    end else if (first_up >= 0 && ev_n == 0 && !err_valid) begin
      up_gap++;
    end
    if (flagD) begin
      dn_n++;
      if (first_dn < 0) first_dn = c;
    end
    if (flagU && flagD) both_n++;
    if (err_valid) begin
      ev_n++;
      ev_err     = phase_err;
      ev_cycle   = c;
      lock_at_ev = int'(locked);
    end
  endtask

  task automatic measure(input int d_in, input int d_fb);
    int len;
    len = ((d_in > d_fb) ? d_in : d_fb) + 8;
    clear_stats();
    for (int c = 0; c < len; c++) begin
      if (c == d_in) IN = 1'b1;
      if (c == d_fb) FB = 1'b1;
      observe(c);
    end
    IN = 1'b0;
    FB = 1'b0;
    for (int c = len; c < len + 6; c++) observe(c);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESET  = 1'b1;
    IN     = 1'b0;
    FB     = 1'b0;
    clear_stats();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_flagU", int'(flagU), 0);
    chk("rst_flagD", int'(flagD), 0);
    chk("rst_err", int'(phase_err), 0);
    chk("rst_valid", int'(err_valid), 0);
    chk("rst_locked", int'(locked), 0);
    RESET = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("idle_flags", int'({flagU, flagD, err_valid}), 0);

    // IN leads by 3
    measure(0, 3);
    chk("lead3_up_n", up_n, 3);
    chk("lead3_first_up", first_up, 2);
    chk("lead3_dn_n", dn_n, 0);
    chk("lead3_ev_n", ev_n, 1);
    chk("lead3_ev_cycle", ev_cycle, 5);
    chk("lead3_err", int'(ev_err), 8'h03);
    chk("lead3_hold", int'(phase_err), 8'h03);

    // FB leads by 5
    measure(5, 0);
    chk("lag5_dn_n", dn_n, 5);
    chk("lag5_first_dn", first_dn, 2);
    chk("lag5_up_n", up_n, 0);
    chk("lag5_ev_n", ev_n, 1);
    chk("lag5_err", int'(ev_err), 8'hFB);

    // Same-cycle edges
    measure(0, 0);
    chk("same_up_n", up_n, 0);
    chk("same_dn_n", dn_n, 0);
    chk("same_ev_n", ev_n, 1);
    chk("same_ev_cycle", ev_cycle, 2);
    chk("same_err", int'(ev_err), 8'h00);

    // Out-of-window measurement clears the lock run, then +1, 0, -1, +1
    measure(0, 3);
    chk("pre_lock", lock_after, 0);
    measure(0, 1);
    chk("seq1_err", int'(ev_err), 8'h01);
    chk("seq1_lock", lock_after, 0);
    measure(0, 0);
    chk("seq2_lock", lock_after, 0);
    measure(1, 0);
    chk("seq3_err", int'(ev_err), 8'hFF);
    chk("seq3_lock", lock_after, 0);
    measure(0, 1);
    chk("seq4_lock_at_ev", lock_at_ev, 0);
    chk("seq4_lock_after", lock_after, 1);
    chk("seq4_both", both_n, 0);
    measure(0, 2);
    chk("plus2_err", int'(ev_err), 8'h02);
    chk("plus2_lock_at_ev", lock_at_ev, 1);
    chk("plus2_lock_after", lock_after, 0);

    for (int i = 0; i < 4; i++) measure(0, 0);
    chk("relock", lock_after, 1);

    // Cycle slip: IN keeps toggling while FB stays low, counter saturates
    clear_stats();
    for (int c = 0; c < 212; c++) begin
      IN = (c < 200) && ((c % 8) < 4);
      FB = (c >= 205);
      observe(c);
    end
    IN = 1'b0;
    FB = 1'b0;
    for (int c = 212; c < 218; c++) observe(c);
    chk("slip_first_up", first_up, 2);
    chk("slip_up_n", up_n, 205);
    chk("slip_gap", up_gap, 0);
    chk("slip_dn_n", dn_n, 0);
    chk("slip_ev_n", ev_n, 1);
    chk("slip_ev_cycle", ev_cycle, 207);
    chk("slip_err", int'(ev_err), 8'h7F);
    chk("slip_lock_at_ev", lock_at_ev, 1);
    chk("slip_lock_after", lock_after, 0);

    // Lock again ending on +1 so reset has nonzero state to clear
    for (int i = 0; i < 3; i++) measure(0, 0);
    measure(0, 1);
    chk("pre_rst_lock", lock_after, 1);

    // Reset while UP with cnt=10
    clear_stats();
    IN = 1'b1;
    for (int c = 0; c < 12; c++) observe(c);
    chk("mid_up_open", int'(flagU), 1);
    chk("mid_up_n", up_n, 10);
    #2;
    RESET = 1'b1;
    #1;
    chk("mid_rst_flagU", int'(flagU), 0);
    chk("mid_rst_err", int'(phase_err), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_valid", int'(err_valid), 0);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    measure(0, 10);
    chk("post_rst_first_up", first_up, 2);
    chk("post_rst_ev_n", ev_n, 1);
    chk("post_rst_ev_cycle", ev_cycle, 12);
    chk("post_rst_err", int'(ev_err), 8'h0A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
